// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and
// access-size decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_RESP
    } state_t;

    // Lane mask of an access at offset 0: 1, 2 or 4 consecutive bytes.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_illegal(input logic store, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (store && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: turns offset/size into per-word enables and shifted
// store data, and reassembles/extends load data from up to two words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rd0,
    input  logic [31:0] rd1,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic        split,
    output logic [31:0] ldata
);

    logic [7:0]  mask;
    logic [63:0] wd64;
    logic [31:0] v;

    // Two adjacent words are treated as one 8-byte window.
    always_comb begin
        mask = {4'b0000, size_mask(funct3)} << off;
        wd64 = {32'h0, wdata} << {off, 3'b000};
        v    = 32'({rd1, rd0} >> {off, 3'b000});
        case (funct3)
            F3_LB:   ldata = {{24{v[7]}}, v[7:0]};
            F3_LH:   ldata = {{16{v[15]}}, v[15:0]};
            F3_LBU:  ldata = {24'h0, v[7:0]};
            F3_LHU:  ldata = {16'h0, v[15:0]};
            default: ldata = v;
        endcase
    end

    assign be0    = mask[3:0];
    assign be1    = mask[7:4];
    assign wdata0 = wd64[31:0];
    assign wdata1 = wd64[63:32];
    assign split  = |mask[7:4];

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, split into one or two word-wide
// memory cycles, load results returned over a valid/ready response.
//   state  | meaning
//   IDLE   | ready for a request
//   ACC0   | memory cycle on the first (or only) word
//   ACC1   | memory cycle on the following word of a split access
//   RESP   | response presented, waiting for resp_ready
module lsu
    import lsu_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic [AWIDTH-3:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_data,
    output logic              resp_err
);

    state_t            state, state_nx;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q, rd0_q, rd1_q, rdata_q;
    logic              err_q;

    logic [3:0]        be0, be1;
    logic [DWIDTH-1:0] wdata0, wdata1, ldata, rd0_cur, rd1_cur;
    logic              split;
    logic [AWIDTH-3:0] word0;

    assign word0 = addr_q[AWIDTH-1:2];

    // The word being read this cycle feeds assembly directly so the result
    // can be registered on the same edge that enters RESP.
    assign rd0_cur = (state == S_ACC0) ? mem_rdata : rd0_q;
    assign rd1_cur = (state == S_ACC1) ? mem_rdata : rd1_q;

    lsu_align u_align (
        .off    (addr_q[1:0]),
        .funct3 (f3_q),
        .wdata  (wdata_q),
        .rd0    (rd0_cur),
        .rd1    (rd1_cur),
        .be0    (be0),
        .be1    (be1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .split  (split),
        .ldata  (ldata)
    );

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = is_illegal(req_store, req_funct3) ? S_RESP : S_ACC0;
            end
            S_ACC0: begin
                mem_addr  = word0;
                mem_be    = be0;
                mem_we    = store_q;
                mem_wdata = wdata0;
                state_nx  = split ? S_ACC1 : S_RESP;
            end
            S_ACC1: begin
                mem_addr  = word0 + (AWIDTH-2)'(1);
                mem_be    = be1;
                mem_we    = store_q;
                mem_wdata = wdata1;
                state_nx  = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (req_valid && req_ready) begin
                store_q <= req_store;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= is_illegal(req_store, req_funct3);
            end
            if (state == S_ACC0 && !store_q)
                rd0_q <= mem_rdata;
            if (state == S_ACC1 && !store_q)
                rd1_q <= mem_rdata;
            if ((state == S_ACC0 || state == S_ACC1) && state_nx == S_RESP)
                rdata_q <= store_q ? '0 : ldata;
        end
    end

    assign resp_data = rdata_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: requests push expected responses, a monitor pops
// and compares on every completed response handshake.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [29:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_x;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem[0:15];

    int          nacc, nwe;
    logic [29:0] acc_addr[0:3];
    logic [3:0]  acc_be[0:3];
    logic [31:0] acc_wd[0:3];
    logic        acc_we[0:3];

    always #5 clk = ~clk;

    lsu #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    assign mem_rdata = mem[mem_addr[3:0]];

    always @(posedge clk)
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr[3:0]][8*i +: 8] <= mem_wdata[8*i +: 8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got data %h err %b expected no response", resp_data, resp_err);
            end else begin
                mon_x = sb.pop_front();
                chk("resp_data", resp_data, mon_x.d);
                chk("resp_err", {31'h0, resp_err}, {31'h0, mon_x.e});
            end
        end
    end

    task automatic record();
        if (mem_we) nwe++;
        if (mem_be != 4'b0000 && nacc < 4) begin
            acc_addr[nacc] = mem_addr;
            acc_be[nacc]   = mem_be;
            acc_wd[nacc]   = mem_wdata;
            acc_we[nacc]   = mem_we;
            nacc++;
        end
    endtask

    task automatic run(input string nm, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input int en, input logic hold);
        int cyc;
        @(negedge clk);
        chk({nm, " req_ready_idle"}, {31'h0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = !hold;
        sb.push_back('{ed, ee});
        @(posedge clk);
        #1 req_valid = 1'b0;
        nacc = 0;
        nwe  = 0;
        cyc  = 1;
        while (!resp_valid && cyc < 12) begin
            record();
            @(posedge clk);
            #1 cyc++;
        end
        chk({nm, " latency"}, cyc, en);
        chk({nm, " resp_valid"}, {31'h0, resp_valid}, 32'd1);
        chk({nm, " req_ready_busy"}, {31'h0, req_ready}, 32'd0);
        if (hold) begin
            repeat (5) begin
                @(posedge clk);
                #1;
                chk({nm, " hold_data"}, resp_data, ed);
                chk({nm, " hold_ready"}, {31'h0, req_ready}, 32'd0);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1 chk({nm, " ready_after"}, {31'h0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        mem[4] <= 32'h8899AABB;
        mem[5] <= 32'h11223344;
        rst = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst resp_data", resp_data, 32'h0);
        chk("rst resp_err", {31'h0, resp_err}, 32'd0);
        chk("rst mem_we_be", {27'h0, mem_we, mem_be}, 32'h0);
        chk("rst mem_addr", {2'b00, mem_addr}, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        @(negedge clk) rst = 1'b1;

        run("lw_aligned", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 1'b0);
        chk("lw_aligned nacc", nacc, 1);
        chk("lw_aligned addr", {2'b00, acc_addr[0]}, 32'd4);
        chk("lw_aligned be", {28'h0, acc_be[0]}, 32'hF);

        run("lb", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1'b0);
        run("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 1'b0);
        run("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 1'b0);

        run("lw_split", 1'b0, 3'b010, 32'h13, 32'h0, 32'h22334488, 1'b0, 3, 1'b0);
        chk("lw_split nacc", nacc, 2);
        chk("lw_split addr0", {2'b00, acc_addr[0]}, 32'd4);
        chk("lw_split addr1", {2'b00, acc_addr[1]}, 32'd5);

        run("sh_split", 1'b1, 3'b001, 32'h17, 32'h0000CAFE, 32'h0, 1'b0, 3, 1'b0);
        chk("sh_split nacc", nacc, 2);
        chk("sh_split addr0", {2'b00, acc_addr[0]}, 32'd5);
        chk("sh_split be0", {28'h0, acc_be[0]}, 32'h8);
        chk("sh_split wd0", acc_wd[0], 32'hFE000000);
        chk("sh_split we0", {31'h0, acc_we[0]}, 32'd1);
        chk("sh_split addr1", {2'b00, acc_addr[1]}, 32'd6);
        chk("sh_split be1", {28'h0, acc_be[1]}, 32'h1);
        chk("sh_split wd1", acc_wd[1], 32'h000000CA);
        chk("sh_split we1", {31'h0, acc_we[1]}, 32'd1);
        chk("sh_split mem5", mem[5], 32'hFE223344);
        chk("sh_split mem6", mem[6], 32'h000000CA);

        run("err_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        chk("err_f3_011 no_we", nwe, 0);
        run("err_sb_100", 1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1, 1, 1'b0);
        chk("err_sb_100 no_we", nwe, 0);

        run("lh_backpressure", 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 1'b1);

        // Split store interrupted by reset while its second word is on the bus.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h17; req_wdata = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid acc1_be", {28'h0, mem_be}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_mid mem_we", {31'h0, mem_we}, 32'd0);
        chk("rst_mid resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_mid req_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        chk("rst_mid mem6", mem[6], 32'h000000CA);
        chk("rst_mid mem5", mem[5], 32'h34223344);

        run("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 1'b0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the data memory. It accepts one load or store request at a time and converts the byte address and access size into word-addressed memory cycles with byte enables. Accesses that cross a word boundary are split into two memory cycles. Load results are returned sign- or zero-extended over a valid/ready response handshake.

## Interface
Parameters:
- AWIDTH, 32, byte address width.
- DWIDTH, 32, data width; fixed at 32 because byte lanes are hard-wired to 4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  AWIDTH  byte address.
- req_wdata  in  DWIDTH  store data, right-aligned.
- mem_addr  out  AWIDTH-2  word index.
- mem_we  out  1  write strobe; the memory writes at posedge when 1.
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- mem_wdata  out  DWIDTH  lane-aligned write data.
- mem_rdata  in  DWIDTH  asynchronous read data for mem_addr.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid & resp_ready.
- resp_data  out  DWIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal funct3.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE
  - req_ready = 1.
  - On accept, latch store, funct3, addr and wdata.
  - Illegal request (funct3 ∈ {011, 110, 111}, or store with funct3[2] = 1): go to RESP with resp_err = 1, no memory cycle.
  - Otherwise go to ACC0.
- Access parameters:
  - off = addr[1:0]; size = 1, 2 or 4 bytes.
  - Split when off + size > 4: LH/SH at off 3, or LW/SW at off 1..3.
- 8-byte lane model:
  - Byte-enable mask = ((1 << size) - 1) << off, 8 bits wide.
  - Write data = wdata << (8 * off), 64 bits wide.
  - Word0 uses bits [3:0] of the mask and [31:0] of the data.
  - Word1 uses bits [7:4] of the mask and [63:32] of the data.
- ACC0
  - mem_addr = addr[AWIDTH-1:2]; mem_be = word0 enables.
  - Store: mem_we = 1.
  - Load: capture mem_rdata into rd0.
  - Next state: ACC1 if split, else RESP.
- ACC1
  - mem_addr = word0 index + 1, wrapping from all-ones to 0.
  - mem_be = word1 enables; mem_we = store.
  - Load: capture mem_rdata into rd1. Next state: RESP.
- Load assembly:
  - v = ({rd1, rd0} >> (8 * off))[31:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW uses v as is.
  - resp_data is registered on entry to RESP.
- RESP
  - resp_valid = 1; resp_data and resp_err held stable.
  - Leave for IDLE on resp_ready. resp_ready low holds RESP indefinitely.
- Outside ACC0/ACC1: mem_we = 0 and mem_be = 0.

## Timing
- Reset values: state IDLE, req_ready = 1, resp_valid = 0, resp_data = 0, resp_err = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
- Cycle counts (accept edge = cycle 0, resp_valid high from the edge of cycle n):
  - Aligned access: n = 2.
  - Split access: n = 3.
  - Illegal request: n = 1.
- Throughput: one request per n + 1 cycles minimum. No request is accepted while busy; req_ready = 0 outside IDLE.
- mem_* outputs are decoded from registered state and latched request only; they never depend combinationally on req_*.
- Reset asserted mid-operation drops to IDLE at once and drives mem_we = 0. A pending ACC1 write does not happen; a completed ACC0 write persists.
- The response handshake completing in RESP makes req_ready = 1 in the next cycle only; there is no same-cycle bypass.

## Structure
- Package lsu_pkg:
  - funct3 encodings (LB, LH, LW, LBU, LHU).
  - State enum.
  - Size decode function.
- Sub-module lsu_align, purely combinational:
  - Inputs: off, funct3, wdata, rd0, rd1.
  - Outputs: be0, be1, wdata0, wdata1, split, extended load value.
- The top holds the FSM and the latch registers.

## Test plan
Memory preload (word index : value): 4 : 0x8899AABB, 5 : 0x11223344.
- LW addr 0x10 → resp_data 0x8899AABB, resp_valid at cycle 2, single memory cycle.
- LB addr 0x13 → 0xFFFFFF88. LBU addr 0x13 → 0x00000088. LHU addr 0x12 → 0x00008899.
- LW addr 0x13 (split) → 0x22334488 at cycle 3. Word indices 4 then 5 seen on mem_addr.
- SH addr 0x17, data 0xCAFE (split):
  - ACC0: word 5, be 1000, wdata 0xFE000000.
  - ACC1: word 6, be 0001, wdata 0x000000CA.
  - Result: word 5 = 0xFE223344.
- Errors and back-pressure:
  - funct3 011 → resp_err = 1, resp_data = 0, no mem_we, cycle 1.
  - SB with funct3 100 → same error response.
  - resp_ready low for 5 cycles → resp_data stable and req_ready stays 0.
- Reset (rst = 0) during ACC1 of the SH above → word 6 is unchanged, state IDLE, resp_valid = 0. The next LW addr 0x10 completes normally.
